// File: rtl/exec_controller.sv
// -----------------------------------------------------------------------------
// exec_controller
//
// Run/stop sequencer for the 5-stage pipelined cpu. It owns the cpu enable
// (PC advance), decides when the external memory ports may reach instruction
// and data memory, and sequences IDLE -> RUN -> DRAIN -> DONE. While running
// it counts executed cycles. When execution stops it records the reason:
// external halt request, halt instruction fetched, or cycle budget exhausted.
//
// Ports
//   clk             in   main clock
//   arst_n          in   reset, synchronous, active-low
//   start           in   pulse; begin execution from IDLE or DONE
//   halt_req        in   external stop request (honoured only in RUN)
//   max_cycles      in   cycle budget, 0 = unlimited; sampled on start
//   if_instruction  in   instruction word currently in IF
//   wen_ext_in      in   external instruction-memory write request
//   ren_ext_in      in   external instruction-memory read request
//   wen_ext_2_in    in   external data-memory write request
//   ren_ext_2_in    in   external data-memory read request
//   enable          out  cpu enable; PC advances when 1
//   fetch_kill      out  IF injects an all-zero NOP into IF/ID
//   wen_ext_out     out  wen_ext_in gated by ext_grant
//   ren_ext_out     out  ren_ext_in gated by ext_grant
//   wen_ext_2_out   out  wen_ext_2_in gated by ext_grant
//   ren_ext_2_out   out  ren_ext_2_in gated by ext_grant
//   ext_grant       out  external memory access allowed (IDLE / DONE)
//   ext_blocked     out  sticky; a request arrived while not granted
//   busy            out  state is RUN or DRAIN
//   done            out  state is DONE
//   stop_cause      out  00 none, 01 halt_req, 10 halt instruction, 11 timeout
//   cycle_count     out  cycles spent in RUN (saturating)
// -----------------------------------------------------------------------------
module exec_controller #(
  parameter int                DATA_W       = 32,
  parameter int                CNT_W        = 32,
  parameter logic [DATA_W-1:0] HALT_WORD    = 32'hFC000000,
  parameter int                DRAIN_CYCLES = 4
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic              halt_req,
  input  logic [CNT_W-1:0]  max_cycles,
  input  logic [DATA_W-1:0] if_instruction,
  input  logic              wen_ext_in,
  input  logic              ren_ext_in,
  input  logic              wen_ext_2_in,
  input  logic              ren_ext_2_in,
  output logic              enable,
  output logic              fetch_kill,
  output logic              wen_ext_out,
  output logic              ren_ext_out,
  output logic              wen_ext_2_out,
  output logic              ren_ext_2_out,
  output logic              ext_grant,
  output logic              ext_blocked,
  output logic              busy,
  output logic              done,
  output logic [1:0]        stop_cause,
  output logic [CNT_W-1:0]  cycle_count
);

  // A drain of zero cycles would let the next run overlap retiring work.
  localparam int DRAIN_LOAD = (DRAIN_CYCLES < 1) ? 1 : DRAIN_CYCLES;
  localparam int DRN_W      = $clog2(DRAIN_LOAD + 1);

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_HREQ  = 2'b01;
  localparam logic [1:0] CAUSE_HINST = 2'b10;
  localparam logic [1:0] CAUSE_TOUT  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_DRAIN = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   budget_q, budget_d;
  logic [1:0]         cause_q, cause_d;
  logic [DRN_W-1:0]   drain_q, drain_d;
  logic               blocked_q, blocked_d;

  // Status outputs are registered copies decoded from the next state so
  // they change exactly with the state register.
  logic               enable_q, enable_d;
  logic               kill_q, kill_d;
  logic               grant_q, grant_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               ext_req;
  logic               timeout;

  // Saturating increment: the counter sticks at all-ones rather than wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

  assign ext_req = wen_ext_in | ren_ext_in | wen_ext_2_in | ren_ext_2_in;

  // Budget check uses the count before this cycle's increment, so a
  // budget of N yields exactly N RUN cycles.
  assign timeout = (budget_q != '0) && (cnt_q == budget_q - CNT_W'(1));

  // ---------------------------------------------------------------------------
  // Next-state and datapath-control logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    budget_d  = budget_q;
    cause_d   = cause_q;
    drain_d   = drain_q;
    // Sticky flag; grant_q is registered so there is no same-cycle race.
    blocked_d = blocked_q | (ext_req & ~grant_q);

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_RUN;
          cnt_d     = '0;
          budget_d  = max_cycles;
          cause_d   = CAUSE_NONE;
          blocked_d = 1'b0;
        end
      end

      S_RUN: begin
        // The stopping cycle is itself a RUN cycle and is counted.
        cnt_d = sat_inc(cnt_q);
        if (halt_req) begin
          cause_d = CAUSE_HREQ;
        end else if (if_instruction == HALT_WORD) begin
          cause_d = CAUSE_HINST;
        end else if (timeout) begin
          cause_d = CAUSE_TOUT;
        end
        if (halt_req || (if_instruction == HALT_WORD) || timeout) begin
          state_d = S_DRAIN;
          drain_d = DRN_W'(DRAIN_LOAD);
        end
      end

      S_DRAIN: begin
        // Count down the in-flight instructions; the last drain cycle is
        // the one where the counter reads 1 (guarding 0 as well).
        if (drain_q <= DRN_W'(1)) begin
          state_d = S_DONE;
          drain_d = '0;
        end else begin
          drain_d = drain_q - DRN_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    enable_d = (state_d == S_RUN);
    kill_d   = (state_d == S_DRAIN);
    grant_d  = (state_d == S_IDLE) || (state_d == S_DONE);
    busy_d   = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d   = (state_d == S_DONE);
  end

  // ---------------------------------------------------------------------------
  // State and status registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      budget_q  <= '0;
      cause_q   <= CAUSE_NONE;
      drain_q   <= '0;
      blocked_q <= 1'b0;
      enable_q  <= 1'b0;
      kill_q    <= 1'b0;
      grant_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      budget_q  <= budget_d;
      cause_q   <= cause_d;
      drain_q   <= drain_d;
      blocked_q <= blocked_d;
      enable_q  <= enable_d;
      kill_q    <= kill_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign enable        = enable_q;
  assign fetch_kill    = kill_q;
  assign ext_grant     = grant_q;
  assign ext_blocked   = blocked_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign stop_cause    = cause_q;
  assign cycle_count   = cnt_q;

  // Combinational gating is hazard-free because ext_grant is a flop output.
  assign wen_ext_out   = wen_ext_in   & grant_q;
  assign ren_ext_out   = ren_ext_in   & grant_q;
  assign wen_ext_2_out = wen_ext_2_in & grant_q;
  assign ren_ext_2_out = ren_ext_2_in & grant_q;

endmodule

// File: tb/tb_exec_controller.sv
module tb_exec_controller;

  localparam logic [31:0] HALT = 32'hFC000000;

  localparam int ST_IDLE  = 0;
  localparam int ST_RUN   = 1;
  localparam int ST_DRAIN = 2;
  localparam int ST_DONE  = 3;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        start;
  logic        halt_req;
  logic [31:0] max_cycles;
  logic [31:0] if_instruction;
  logic        wen_ext_in, ren_ext_in, wen_ext_2_in, ren_ext_2_in;
  logic        enable, fetch_kill;
  logic        wen_ext_out, ren_ext_out, wen_ext_2_out, ren_ext_2_out;
  logic        ext_grant, ext_blocked, busy, done;
  logic [1:0]  stop_cause;
  logic [31:0] cycle_count;

  exec_controller #(
    .DATA_W(32), .CNT_W(32), .HALT_WORD(32'hFC000000), .DRAIN_CYCLES(4)
  ) dut (
    .clk(clk), .arst_n(arst_n), .start(start), .halt_req(halt_req),
    .max_cycles(max_cycles), .if_instruction(if_instruction),
    .wen_ext_in(wen_ext_in), .ren_ext_in(ren_ext_in),
    .wen_ext_2_in(wen_ext_2_in), .ren_ext_2_in(ren_ext_2_in),
    .enable(enable), .fetch_kill(fetch_kill),
    .wen_ext_out(wen_ext_out), .ren_ext_out(ren_ext_out),
    .wen_ext_2_out(wen_ext_2_out), .ren_ext_2_out(ren_ext_2_out),
    .ext_grant(ext_grant), .ext_blocked(ext_blocked), .busy(busy),
    .done(done), .stop_cause(stop_cause), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_run  = 0;
  int n_fail = 0;

  // Scoreboard: expected output vector tagged with the cycle it applies to.
  int          q_cyc[$];
  logic [43:0] q_v[$];
  string       q_nm[$];

  // {enable, fetch_kill, ext_grant, ext_blocked, busy, done, stop_cause,
  //  wen_out, ren_out, wen2_out, ren2_out, cycle_count}
  function automatic logic [43:0] exp_v(input int st, input logic blk,
                                        input logic [1:0] cause,
                                        input logic [3:0] gated,
                                        input logic [31:0] cnt);
    logic en, fk, g, bz, dn;
    case (st)
      ST_RUN:   begin en = 1; fk = 0; g = 0; bz = 1; dn = 0; end
      ST_DRAIN: begin en = 0; fk = 1; g = 0; bz = 1; dn = 0; end
      ST_DONE:  begin en = 0; fk = 0; g = 1; bz = 0; dn = 1; end
      default:  begin en = 0; fk = 0; g = 1; bz = 0; dn = 0; end
    endcase
    return {en, fk, g, blk, bz, dn, cause, gated, cnt};
  endfunction

  task automatic chk(input string nm, input int st, input logic blk,
                     input logic [1:0] cause, input logic [3:0] gated,
                     input logic [31:0] cnt);
    q_cyc.push_back(cyc);
    q_v.push_back(exp_v(st, blk, cause, gated, cnt));
    q_nm.push_back(nm);
  endtask

  // Monitor: compares whenever an expectation for the present cycle exists.
  always @(negedge clk) begin
    logic [43:0] act, e;
    int          ec;
    string       nm;
    act = {enable, fetch_kill, ext_grant, ext_blocked, busy, done, stop_cause,
           wen_ext_out, ren_ext_out, wen_ext_2_out, ren_ext_2_out, cycle_count};
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      ec = q_cyc.pop_front();
      e  = q_v.pop_front();
      nm = q_nm.pop_front();
      n_run++;
      if (ec != cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", nm, ec, cyc);
      end else if (act !== e) begin
        n_fail++;
        $display("FAIL %s: cycle %0d actual=%h required=%h", nm, cyc, act, e);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bit got_done;
    arst_n = 0; start = 0; halt_req = 0; max_cycles = 0; if_instruction = 0;
    wen_ext_in = 0; ren_ext_in = 0; wen_ext_2_in = 0; ren_ext_2_in = 0;

    // Reset state
    step(2);
    chk("reset", ST_IDLE, 0, 2'b00, 4'b0000, 0);
    arst_n = 1;
    step(1);
    halt_req = 1;  // ignored in IDLE
    chk("idle_hold", ST_IDLE, 0, 2'b00, 4'b0000, 0);

    // Unlimited run, external request blocking, halt_req stop
    step(1);
    halt_req = 0; start = 1; max_cycles = 0;
    chk("idle_start", ST_IDLE, 0, 2'b00, 4'b0000, 0);
    step(1);
    start = 0;
    chk("run_first", ST_RUN, 0, 2'b00, 4'b0000, 0);
    for (int i = 1; i <= 10; i++) begin
      step(1);
      chk("run_count", ST_RUN, 0, 2'b00, 4'b0000, 32'(i));
    end
    wen_ext_in = 1;  // gated off while running
    chk("run_wen_gated", ST_RUN, 0, 2'b00, 4'b0000, 10);
    step(1);
    wen_ext_in = 0; halt_req = 1;
    chk("blocked_set", ST_RUN, 1, 2'b00, 4'b0000, 11);
    step(1);
    halt_req = 0;
    chk("hreq_drain", ST_DRAIN, 1, 2'b01, 4'b0000, 12);
    step(3);
    chk("hreq_drain_last", ST_DRAIN, 1, 2'b01, 4'b0000, 12);
    step(1);
    max_cycles = 5; start = 1;
    chk("hreq_done", ST_DONE, 1, 2'b01, 4'b0000, 12);

    // Budget of 5 cycles
    step(1);
    start = 0;
    for (int i = 0; i < 5; i++) begin
      chk("budget_run", ST_RUN, 0, 2'b00, 4'b0000, 32'(i));
      step(1);
    end
    for (int i = 0; i < 4; i++) begin
      chk("budget_drain", ST_DRAIN, 0, 2'b11, 4'b0000, 5);
      if (i == 1) begin start = 1; halt_req = 1; end
      else begin start = 0; halt_req = 0; end
      step(1);
    end
    max_cycles = 0; start = 1;
    chk("budget_done", ST_DONE, 0, 2'b11, 4'b0000, 5);

    // Halt instruction on RUN cycle 3 (near-miss word on cycle 2)
    step(1);
    start = 0;
    chk("hi_c1", ST_RUN, 0, 2'b00, 4'b0000, 0);
    step(1);
    if_instruction = 32'hFC000001;
    chk("hi_c2", ST_RUN, 0, 2'b00, 4'b0000, 1);
    step(1);
    if_instruction = HALT;
    chk("hi_c3", ST_RUN, 0, 2'b00, 4'b0000, 2);
    step(1);
    if_instruction = 0;
    chk("hi_drain", ST_DRAIN, 0, 2'b10, 4'b0000, 3);
    step(3);
    chk("hi_drain_last", ST_DRAIN, 0, 2'b10, 4'b0000, 3);
    step(1);
    ren_ext_2_in = 1;
    chk("hi_done_ren2", ST_DONE, 0, 2'b10, 4'b0001, 3);

    // halt_req together with HALT_WORD and budget 1
    step(1);
    ren_ext_2_in = 0; max_cycles = 1; start = 1;
    chk("both_pre", ST_DONE, 0, 2'b10, 4'b0000, 3);
    step(1);
    start = 0; halt_req = 1; if_instruction = HALT;
    chk("both_run", ST_RUN, 0, 2'b00, 4'b0000, 0);
    step(1);
    halt_req = 0; if_instruction = 0;
    chk("both_drain", ST_DRAIN, 0, 2'b01, 4'b0000, 1);
    step(4);
    max_cycles = 2; start = 1;
    chk("both_done", ST_DONE, 0, 2'b01, 4'b0000, 1);

    // Reset during DRAIN, then start and halt_req in the same IDLE cycle
    step(1);
    start = 0;
    chk("rst_run0", ST_RUN, 0, 2'b00, 4'b0000, 0);
    step(1);
    chk("rst_run1", ST_RUN, 0, 2'b00, 4'b0000, 1);
    step(1);
    arst_n = 0;
    chk("rst_drain", ST_DRAIN, 0, 2'b11, 4'b0000, 2);
    step(1);
    arst_n = 1; wen_ext_in = 1; start = 1; halt_req = 1; max_cycles = 0;
    chk("rst_values", ST_IDLE, 0, 2'b00, 4'b1000, 0);
    step(1);
    start = 0; halt_req = 0; wen_ext_in = 0;
    chk("rst_restart", ST_RUN, 0, 2'b00, 4'b0000, 0);
    step(1);
    halt_req = 1;
    chk("rst_run_cont", ST_RUN, 0, 2'b00, 4'b0000, 1);
    step(1);
    halt_req = 0;
    chk("rst_stop", ST_DRAIN, 0, 2'b01, 4'b0000, 2);

    // Bounded wait for completion
    got_done = 0;
    for (int i = 0; i < 10 && !got_done; i++) begin
      step(1);
      if (done) got_done = 1;
    end
    n_run++;
    if (!got_done) begin
      n_fail++;
      $display("FAIL done_wait: done=%0b after 10 cycles, required 1", done);
    end

    step(2);
    n_run++;
    if (q_cyc.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expectations left, required 0", q_cyc.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_controller.md
Name: exec_controller

Overview:
- Run/stop sequencer for the 5-stage pipelined cpu.
- Owns the cpu `enable` (PC advance) and decides when the external memory ports may reach instruction and data memory.
- Sequences load -> run -> pipeline drain -> done.
- Counts executed cycles and reports why execution stopped: external halt request, halt instruction fetched, or cycle budget exhausted.

Parameters:
- DATA_W, 32, width of the fetched instruction word and of HALT_WORD.
- CNT_W, 32, width of cycle_count and max_cycles.
- HALT_WORD, 32'hFC000000, fetched instruction encoding that stops execution.
- DRAIN_CYCLES, 4, cycles the PC stays frozen so in-flight instructions retire through WB; minimum 1.

Ports:
- clk  in  1  main clock
- arst_n  in  1  reset; synchronous, active-low
- start  in  1  pulse; begin execution from IDLE or DONE
- halt_req  in  1  external stop request
- max_cycles  in  CNT_W  cycle budget; 0 = unlimited; sampled on start
- if_instruction  in  DATA_W  instruction currently in IF
- wen_ext_in  in  1  external instruction-memory write request
- ren_ext_in  in  1  external instruction-memory read request
- wen_ext_2_in  in  1  external data-memory write request
- ren_ext_2_in  in  1  external data-memory read request
- enable  out  1  to cpu enable; PC advances when 1
- fetch_kill  out  1  IF must inject NOP (all-zero word) into IF/ID
- wen_ext_out  out  1  gated external instruction-memory write
- ren_ext_out  out  1  gated external instruction-memory read
- wen_ext_2_out  out  1  gated external data-memory write
- ren_ext_2_out  out  1  gated external data-memory read
- ext_grant  out  1  external memory access allowed
- ext_blocked  out  1  sticky; an external request arrived while not granted
- busy  out  1  state is RUN or DRAIN
- done  out  1  state is DONE
- stop_cause  out  2  00 none, 01 halt_req, 10 halt instruction, 11 timeout
- cycle_count  out  CNT_W  cycles spent in RUN

Behaviour:
- Reset (arst_n=0 at a clk edge):
  - state=IDLE, enable=0, fetch_kill=0, ext_grant=1, ext_blocked=0.
  - busy=0, done=0, stop_cause=00, cycle_count=0.
  - Drain counter = 0, latched budget = 0.
  - Reset mid-RUN or mid-DRAIN aborts immediately with the same values.
- Output timing:
  - All status outputs are registered, decoded from the state.
  - The four gated *_out signals are combinational: each *_in AND ext_grant. No cross-state hazard exists because ext_grant is registered.
- IDLE (enable=0, ext_grant=1):
  - start=1 -> RUN; cycle_count cleared to 0; max_cycles latched; stop_cause cleared to 00; ext_blocked cleared.
  - halt_req is ignored in IDLE.
- RUN (enable=1, ext_grant=0, busy=1):
  - enable rises the cycle after start is sampled.
  - cycle_count += 1 every RUN cycle; saturates at all-ones.
  - Stop conditions, evaluated in priority order:
    1. halt_req=1 -> cause 01.
    2. if_instruction==HALT_WORD -> cause 10.
    3. latched budget !=0 and cycle_count==budget-1 -> cause 11. This gives exactly `budget` RUN cycles.
  - Any stop condition -> DRAIN, latch cause, load drain counter with DRAIN_CYCLES.
  - start in RUN is ignored.
- DRAIN (enable=0, fetch_kill=1, ext_grant=0, busy=1):
  - Drain counter decrements each cycle.
  - At 1 -> DONE.
  - halt_req and start are ignored.
  - cycle_count holds.
- DONE (done=1, ext_grant=1, enable=0):
  - cycle_count and stop_cause hold.
  - start=1 -> RUN with the same clearing as from IDLE.
- ext_blocked:
  - Set when any *_in=1 while ext_grant=0.
  - Cleared only by reset or by start.
- Simultaneous events:
  - halt_req and HALT_WORD in the same cycle -> cause 01.
  - Halt and timeout in the same cycle -> halt cause wins.
  - start and halt_req in the same IDLE cycle -> RUN; halt_req is evaluated from the next cycle.

Test Plan:
- Reset then start with max_cycles=0, no halt -> enable=1 from cycle after start; cycle_count=10 after 10 cycles; ext_grant=0; wen_ext_in=1 gives wen_ext_out=0 and ext_blocked=1.
- Start with max_cycles=5 -> exactly 5 cycles with enable=1; fetch_kill=1 for 4 cycles; then done=1, stop_cause=11, cycle_count=5.
- if_instruction=32'hFC000000 on RUN cycle 3 -> DRAIN next cycle; stop_cause=10; DONE 4 cycles later; cycle_count=3.
- halt_req and HALT_WORD together, with max_cycles=1 -> stop_cause=01 after a single RUN cycle.
- arst_n=0 during DRAIN -> next cycle all outputs at reset values and ext_grant=1; start afterwards runs normally.
- In DONE: ren_ext_2_in=1 -> ren_ext_2_out=1. Then start again -> cycle_count restarts at 0 and stop_cause=00 while running.
